// File: rtl/ifm_line_loader.sv
// Loads one feature-map row from the channel-planar input RAM into the pixel-major line buffer.
// An all-zero row is written when the requested row lies outside the map.
module ifm_line_loader #(
  parameter int IFM_DATA_NUM  = 4,
  parameter int W_BRAM_DATA_W = 16,
  parameter int RD_LAT        = 1,
  parameter int MAX_IFM_W     = 256,
  parameter int MAX_IFM_H     = 256,
  parameter int MAX_ICH       = 256,
  localparam int RA_W   = $clog2(MAX_ICH*MAX_IFM_H*MAX_IFM_W/IFM_DATA_NUM),
  localparam int SL_MAX = (MAX_ICH + W_BRAM_DATA_W - 1)/W_BRAM_DATA_W,
  localparam int WA_W   = $clog2(MAX_IFM_W*SL_MAX)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [8:0]                   ifm_w,
  input  logic [8:0]                   ifm_h,
  input  logic [8:0]                   ich,
  input  logic [9:0]                   line_idx,
  input  logic                         ap_start,
  output logic                         ap_busy,
  output logic                         ap_done,
  output logic                         r_en,
  output logic [RA_W-1:0]              r_addr,
  input  logic [8*IFM_DATA_NUM-1:0]    r_data,
  output logic                         w_en,
  output logic [WA_W-1:0]              w_addr,
  output logic [8*W_BRAM_DATA_W-1:0]   w_data
);

  localparam int NW  = $clog2(IFM_DATA_NUM);
  localparam int KW  = $clog2(W_BRAM_DATA_W);
  localparam int GW  = $clog2(MAX_IFM_W/IFM_DATA_NUM + 1);
  localparam int SW  = $clog2(SL_MAX + 1);
  localparam int PW  = $clog2(MAX_IFM_H*MAX_IFM_W/IFM_DATA_NUM + 1);
  localparam int PAW = $clog2(MAX_IFM_W*SL_MAX + 1);
  localparam int DW  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_PAD   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [GW-1:0]  g_q, g_d, g_n_q, g_n_d;
  logic [SW-1:0]  s_q, s_d, s_n_q, s_n_d;
  logic [KW-1:0]  k_q, k_d;
  logic [NW-1:0]  j_q, j_d;
  logic [DW-1:0]  dr_q, dr_d;
  logic [PAW-1:0] pa_q, pa_d, pad_n_q, pad_n_d;
  logic [PW-1:0]  p_q, p_d;
  logic [RA_W-1:0] rb_q, rb_d;
  logic [8:0]     ich_q, ich_d;
  logic           done_d, done_q, busy_d, busy_q;
  logic           r_en_d, r_en_q, w_en_d, w_en_q;
  logic [RA_W-1:0] r_addr_d, r_addr_q;
  logic [WA_W-1:0] w_addr_d, w_addr_q;
  logic [8*W_BRAM_DATA_W-1:0] w_data_d, w_data_q;
  logic [RD_LAT-1:0]          pv_q, pv_d;
  logic [RD_LAT-1:0][KW-1:0]  pk_q, pk_d;
  logic [IFM_DATA_NUM-1:0][8*W_BRAM_DATA_W-1:0] lbuf_q, lbuf_d, lbuf_cap_s;
  logic           row_ok_s, last_s_s, last_g_s, enter_read_s;
  logic [31:0]    c_s;

  // Sequencing: state, loop counters and per-row configuration.
  always_comb begin
    state_d = state_q;
    g_d = g_q; s_d = s_q; k_d = k_q; j_d = j_q; dr_d = dr_q; pa_d = pa_q;
    g_n_d = g_n_q; s_n_d = s_n_q; p_d = p_q; rb_d = rb_q; ich_d = ich_q; pad_n_d = pad_n_q;
    done_d = 1'b0;
    row_ok_s = !line_idx[9] && (line_idx[8:0] < ifm_h);
    last_s_s = (32'(s_q) + 32'd1) == 32'(s_n_q);
    last_g_s = (32'(g_q) + 32'd1) == 32'(g_n_q);
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          g_n_d   = GW'(ifm_w >> NW);
          s_n_d   = SW'((32'(ich) + 32'(W_BRAM_DATA_W) - 32'd1) >> KW);
          p_d     = PW'(32'(ifm_h) * 32'(g_n_d));
          rb_d    = RA_W'(32'(line_idx[8:0]) * 32'(g_n_d));
          pad_n_d = PAW'(32'(ifm_w) * 32'(s_n_d));
          ich_d   = ich;
          g_d = '0; s_d = '0; k_d = '0; j_d = '0; dr_d = '0; pa_d = '0;
          state_d = row_ok_s ? S_READ : S_PAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (k_q == KW'(W_BRAM_DATA_W - 1)) begin
          state_d = S_DRAIN;
          dr_d    = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (dr_q == DW'(RD_LAT - 1)) begin
          state_d = S_WRITE;
          j_d     = '0;
        end else begin
          dr_d = dr_q + DW'(1);
        end
      end
      S_WRITE: begin
        if (j_q == NW'(IFM_DATA_NUM - 1)) begin
          if (last_s_s && last_g_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (last_s_s) begin
            state_d = S_READ; k_d = '0; s_d = '0; g_d = g_q + GW'(1);
          end else begin
            state_d = S_READ; k_d = '0; s_d = s_q + SW'(1);
          end
        end else begin
          j_d = j_q + NW'(1);
        end
      end
      S_PAD: begin
        if ((32'(pa_q) + 32'd1) == 32'(pad_n_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          pa_d = pa_q + PAW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: read-return capture, buffer clearing and next-cycle output values.
  always_comb begin
    pv_d[0] = r_en_q;
    pk_d[0] = k_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pk_d[i] = pk_q[i-1];
    end
    // Lane k of every pixel buffer takes pixel i of the word returned for read k.
    for (int i = 0; i < IFM_DATA_NUM; i++) begin
      for (int k = 0; k < W_BRAM_DATA_W; k++) begin
        lbuf_cap_s[i][8*k +: 8] = (pv_q[RD_LAT-1] && (pk_q[RD_LAT-1] == KW'(k))) ?
                                  r_data[8*i +: 8] : lbuf_q[i][8*k +: 8];
      end
    end
    enter_read_s = (state_d == S_READ) && (state_q != S_READ);
    lbuf_d   = enter_read_s ? '0 : lbuf_cap_s;
    c_s      = 32'(s_d) * 32'(W_BRAM_DATA_W) + 32'(k_d);
    r_en_d   = (state_d == S_READ) && (c_s < 32'(ich_d));
    r_addr_d = r_en_d ? RA_W'(c_s * 32'(p_d) + 32'(rb_d) + 32'(g_d)) : '0;
    w_en_d   = (state_d == S_WRITE) || (state_d == S_PAD);
    if (state_d == S_WRITE) begin
      w_addr_d = WA_W'((32'(g_d) * 32'(IFM_DATA_NUM) + 32'(j_d)) * 32'(s_n_d) + 32'(s_d));
      w_data_d = lbuf_d[j_d];
    end else if (state_d == S_PAD) begin
      w_addr_d = WA_W'(pa_d);
      w_data_d = '0;
    end else begin
      w_addr_d = '0;
      w_data_d = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q <= '0; s_q <= '0; k_q <= '0; j_q <= '0; dr_q <= '0; pa_q <= '0;
      g_n_q <= '0; s_n_q <= '0; p_q <= '0; rb_q <= '0; ich_q <= '0; pad_n_q <= '0;
      pv_q <= '0; pk_q <= '0; lbuf_q <= '0;
      done_q <= 1'b0; busy_q <= 1'b0; r_en_q <= 1'b0; w_en_q <= 1'b0;
      r_addr_q <= '0; w_addr_q <= '0; w_data_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d; s_q <= s_d; k_q <= k_d; j_q <= j_d; dr_q <= dr_d; pa_q <= pa_d;
      g_n_q <= g_n_d; s_n_q <= s_n_d; p_q <= p_d; rb_q <= rb_d; ich_q <= ich_d; pad_n_q <= pad_n_d;
      pv_q <= pv_d; pk_q <= pk_d; lbuf_q <= lbuf_d;
      done_q <= done_d; busy_q <= busy_d; r_en_q <= r_en_d; w_en_q <= w_en_d;
      r_addr_q <= r_addr_d; w_addr_q <= w_addr_d; w_data_q <= w_data_d;
    end
  end

  assign ap_busy = busy_q;
  assign ap_done = done_q;
  assign r_en    = r_en_q;
  assign r_addr  = r_addr_q;
  assign w_en    = w_en_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;

endmodule

// File: tb/tb_ifm_line_loader.sv
// Bench for ifm_line_loader: two instances (4/16/RD1 and 8/8/RD3) driven by a vector table and random rows,
// checked against a pixel-level model of the row copy and its timing.
module tb_ifm_line_loader;
  localparam int RA0 = $clog2(256*256*256/4);
  localparam int WA0 = $clog2(256*16);
  localparam int RA1 = $clog2(256*256*256/8);
  localparam int WA1 = $clog2(256*32);

  typedef struct {
    int sel; int w; int h; int ich; int line;
    int first; int done; int nr; int nw;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  logic [8:0] ifm_w, ifm_h, ich;
  logic [9:0] line_idx;
  logic ap_start0, ap_start1;
  logic busy0, done0, r_en0, w_en0, busy1, done1, r_en1, w_en1;
  logic [RA0-1:0] r_addr0;
  logic [RA1-1:0] r_addr1;
  logic [WA0-1:0] w_addr0;
  logic [WA1-1:0] w_addr1;
  logic [31:0]  r_data0, rq0;
  logic [63:0]  r_data1, rq1a, rq1b, rq1c;
  logic [127:0] w_data0;
  logic [63:0]  w_data1;

  assign ap_start0 = start & ~sel;
  assign ap_start1 = start & sel;

  ifm_line_loader dut0 (
    .clk(clk), .rst(rst), .ifm_w(ifm_w), .ifm_h(ifm_h), .ich(ich), .line_idx(line_idx),
    .ap_start(ap_start0), .ap_busy(busy0), .ap_done(done0), .r_en(r_en0), .r_addr(r_addr0),
    .r_data(r_data0), .w_en(w_en0), .w_addr(w_addr0), .w_data(w_data0));

  ifm_line_loader #(.IFM_DATA_NUM(8), .W_BRAM_DATA_W(8), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .ifm_w(ifm_w), .ifm_h(ifm_h), .ich(ich), .line_idx(line_idx),
    .ap_start(ap_start1), .ap_busy(busy1), .ap_done(done1), .r_en(r_en1), .r_addr(r_addr1),
    .r_data(r_data1), .w_en(w_en1), .w_addr(w_addr1), .w_data(w_data1));

  function automatic logic [7:0] pix(input int a, input int i);
    int v;
    v = a*37 + i*101 + a/32 + 3;
    return 8'(v ^ (v >> 8));
  endfunction

  function automatic logic [63:0] word(input int a, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = pix(a, i);
    return r;
  endfunction

  // Input RAMs; unrequested slots return garbage.
  always @(posedge clk) begin
    rq0  <= r_en0 ? 32'(word(int'(r_addr0), 4)) : $urandom;
    rq1a <= r_en1 ? word(int'(r_addr1), 8) : {$urandom, $urandom};
    rq1b <= rq1a;
    rq1c <= rq1b;
  end
  assign r_data0 = rq0;
  assign r_data1 = rq1c;

  logic o_busy, o_done, o_ren, o_wen;
  int o_raddr, o_waddr;
  logic [127:0] o_wdata;
  always_comb begin
    o_busy  = sel ? busy1 : busy0;
    o_done  = sel ? done1 : done0;
    o_ren   = sel ? r_en1 : r_en0;
    o_wen   = sel ? w_en1 : w_en0;
    o_raddr = sel ? int'(r_addr1) : int'(r_addr0);
    o_waddr = sel ? int'(w_addr1) : int'(w_addr0);
    o_wdata = sel ? {64'd0, w_data1} : w_data0;
  end

  int errors = 0, checks = 0;
  int exp_ra[$], exp_wa[$];
  logic [127:0] exp_wd[$];

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: copy pixels (c,line,x) to line-buffer word x*S + c/W, lane c%W.
  task automatic build_model(input vec_t v);
    int n, wl, gn, sn, p, c, x;
    logic [127:0] d;
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    n = v.sel ? 8 : 4;
    wl = v.sel ? 8 : 16;
    gn = v.w / n; sn = (v.ich + wl - 1) / wl; p = v.h * gn;
    if (v.line < 0 || v.line >= v.h) begin
      for (int a = 0; a < v.w*sn; a++) begin exp_wa.push_back(a); exp_wd.push_back('0); end
    end else begin
      for (int g = 0; g < gn; g++) begin
        for (int s = 0; s < sn; s++) begin
          for (int k = 0; k < wl; k++) begin
            c = s*wl + k;
            if (c < v.ich) exp_ra.push_back(c*p + v.line*gn + g);
          end
          for (int j = 0; j < n; j++) begin
            x = g*n + j;
            d = '0;
            for (int k = 0; k < wl; k++) begin
              c = s*wl + k;
              if (c < v.ich) d[8*k +: 8] = pix(c*p + v.line*gn + x/n, x % n);
            end
            exp_wa.push_back(x*sn + s);
            exp_wd.push_back(d);
          end
        end
      end
    end
  endtask

  function automatic vec_t rand_vec(input int s);
    vec_t v;
    int n, wl, rd, gn, sn;
    n = s ? 8 : 4; wl = s ? 8 : 16; rd = s ? 3 : 1;
    v.sel = s;
    v.w = n * int'($urandom_range(1, 4));
    v.h = int'($urandom_range(1, 5));
    v.ich = int'($urandom_range(1, 40));
    v.line = int'($urandom_range(0, v.h + 3)) - 2;
    gn = v.w / n; sn = (v.ich + wl - 1) / wl;
    v.nw = v.w * sn;
    if (v.line >= 0 && v.line < v.h) begin
      v.first = 1 + wl + rd;
      v.done = 1 + gn*sn*(wl + rd + n);
      v.nr = gn * v.ich;
    end else begin
      v.first = 1; v.done = v.w*sn + 1; v.nr = 0;
    end
    return v;
  endfunction

  task automatic run_row(input vec_t v, input bit hold, input bit poke);
    int nr, nw, n;
    bit fin;
    nr = 0; nw = 0; fin = 1'b0; n = 0;
    sel = v.sel[0];
    build_model(v);
    @(negedge clk);
    ifm_w = 9'(v.w); ifm_h = 9'(v.h); ich = 9'(v.ich); line_idx = 10'(v.line);
    start = 1'b1;
    @(posedge clk);
    while (!fin && n < 3000) begin
      @(negedge clk);
      n++;
      start = hold || (poke && (n == 5 || n == 20));
      if (n < v.done) chk_i("busy_during_row", int'(o_busy), 1);
      if (o_ren) begin
        nr++;
        if (exp_ra.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got r_addr %0d expected no read at cycle %0d", o_raddr, n);
        end else chk_i("r_addr", o_raddr, exp_ra.pop_front());
      end
      if (o_wen) begin
        nw++;
        if (nw == 1) chk_i("first_wen_cycle", n, v.first);
        if (exp_wa.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got w_addr %0d expected no write at cycle %0d", o_waddr, n);
        end else begin
          chk_i("w_addr", o_waddr, exp_wa.pop_front());
          chk_d("w_data", o_wdata, exp_wd.pop_front());
        end
      end
      if (o_done) begin
        chk_i("done_cycle", n, v.done);
        chk_i("busy_at_done", int'(o_busy), 0);
        fin = 1'b1;
      end
    end
    if (!fin) chk_i("done_timeout", 0, 1);
    chk_i("num_reads", nr, v.nr);
    chk_i("num_writes", nw, v.nw);
    @(negedge clk);
    if (hold) chk_i("restart_when_held", int'(o_busy), 1);
    else begin
      chk_i("done_pulse_width", int'(o_done), 0);
      chk_i("idle_after_done", int'(o_busy), 0);
    end
    start = 1'b0;
  endtask

  vec_t tbl[8];
  int bad;

  initial begin
    tbl[0] = '{0, 8, 8, 16,  3, 18, 43, 32,  8};
    tbl[1] = '{0, 4, 8, 20,  2, 18, 43, 20,  8};
    tbl[2] = '{0, 8, 8, 32, -1,  1, 17,  0, 16};
    tbl[3] = '{0, 8, 8, 32,  8,  1, 17,  0, 16};
    tbl[4] = '{0, 4, 1,  1,  0, 18, 22,  1,  4};
    tbl[5] = '{1, 16, 4, 12, 1, 12, 77, 24, 32};
    tbl[6] = '{1, 8, 3,  8,  2, 12, 20,  8,  8};
    tbl[7] = '{1, 8, 3, 20,  3,  1, 25,  0, 24};

    rst = 1'b1; start = 1'b0; sel = 1'b0;
    ifm_w = '0; ifm_h = '0; ich = '0; line_idx = '0;
    repeat (3) @(negedge clk);
    chk_i("rst_busy", int'(busy0 | busy1), 0);
    chk_i("rst_done", int'(done0 | done1), 0);
    chk_i("rst_ren", int'(r_en0 | r_en1), 0);
    chk_i("rst_wen", int'(w_en0 | w_en1), 0);
    chk_i("rst_raddr", int'(r_addr0) + int'(r_addr1), 0);
    chk_i("rst_waddr", int'(w_addr0) + int'(w_addr1), 0);
    chk_d("rst_wdata", w_data0 | {64'd0, w_data1}, '0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_row(tbl[i], 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_row(rand_vec(i % 2), 1'b0, 1'b0);

    // ap_start held high restarts at once; abort the new row with reset.
    run_row(tbl[2], 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_i("idle_after_abort", int'(o_busy), 0);

    // Reset during WRITE of group 0, then a clean row with ignored ap_start pulses.
    sel = 1'b0;
    @(negedge clk);
    ifm_w = 9'd8; ifm_h = 9'd8; ich = 9'd16; line_idx = 10'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk_i("in_write_before_reset", int'(w_en0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_i("mid_rst_busy", int'(busy0), 0);
    chk_i("mid_rst_done", int'(done0), 0);
    chk_i("mid_rst_wen", int'(w_en0), 0);
    chk_i("mid_rst_waddr", int'(w_addr0), 0);
    chk_d("mid_rst_wdata", w_data0, '0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 || w_en0 || r_en0 || busy0) bad++;
    end
    chk_i("no_activity_after_reset", bad, 0);
    run_row(tbl[0], 1'b0, 1'b1);
    run_row(tbl[1], 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifm_line_loader.md
# ifm_line_loader

Loads one feature-map row from the channel-planar input RAM into the pixel-major line buffer consumed by the convolution datapath. It is the parametrised successor of the current line loader:
- generalises width, height, channel count and input-RAM read latency;
- supports channel counts that are not a multiple of the slice width, zero-filling the missing lanes;
- writes an all-zero padding row when the requested row lies outside the feature map.

It sits between the IFM BRAM and the per-row line buffers and is started once per row by the layer controller.

## Interface
Parameters:
- IFM_DATA_NUM, 4: pixels per input-RAM word (power of two, 2..16).
- W_BRAM_DATA_W, 16: channels per line-buffer word (power of two, 4..32).
- RD_LAT, 1: input-RAM read latency in cycles (1..4).
- MAX_IFM_W, 256; MAX_IFM_H, 256; MAX_ICH, 256: sizing limits.
- Derived:
  - RA_W = clog2(MAX_ICH*MAX_IFM_H*MAX_IFM_W/IFM_DATA_NUM)
  - SL_MAX = ceil(MAX_ICH/W_BRAM_DATA_W)
  - WA_W = clog2(MAX_IFM_W*SL_MAX)

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- ifm_w  in  9  row width in pixels, 1..MAX_IFM_W, multiple of IFM_DATA_NUM.
- ifm_h  in  9  map height, 1..MAX_IFM_H.
- ich  in  9  channel count, 1..MAX_ICH.
- line_idx  in  10  signed row index.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_busy  out  1  high from the cycle after acceptance until ap_done.
- ap_done  out  1  one-cycle completion pulse.
- r_en  out  1  input-RAM read enable.
- r_addr  out  RA_W  input-RAM word address.
- r_data  in  8*IFM_DATA_NUM  input-RAM data; pixel i in bits [8i+7:8i].
- w_en  out  1  line-buffer write enable.
- w_addr  out  WA_W  line-buffer address.
- w_data  out  8*W_BRAM_DATA_W  line-buffer data; lane k in bits [8k+7:8k].

All outputs are registered and reset to 0.

## Operation
- Configuration inputs (ifm_w, ifm_h, ich, line_idx) are captured at acceptance and held until done.
- Derived quantities:
  - G = ifm_w/IFM_DATA_NUM (pixel groups)
  - S = ceil(ich/W_BRAM_DATA_W) (channel slices)
  - P = ifm_h*ifm_w/IFM_DATA_NUM (words per channel plane)
- Input layout: pixel (c,y,x) is in word c*P + y*G + x/IFM_DATA_NUM, lane x mod IFM_DATA_NUM.
- Output layout: channel c of pixel x is in word x*S + c/W_BRAM_DATA_W, lane c mod W_BRAM_DATA_W.
- States: IDLE, READ, DRAIN, WRITE, PAD.
- IDLE --ap_start, 0<=line_idx<ifm_h--> READ. IDLE --ap_start, otherwise--> PAD.
- Loop order: group g outer (0..G-1), slice s inner (0..S-1).
- READ: W_BRAM_DATA_W cycles, k = 0..W_BRAM_DATA_W-1, channel c = s*W_BRAM_DATA_W + k.
  - If c < ich: r_en=1, r_addr = c*P + line_idx*G + g.
  - If c >= ich: r_en=0 and lane k of all IFM_DATA_NUM buffers is forced to 0.
- Capture: data returned for read k is stored as lane k of buffer i, taken from pixel i of r_data.
- DRAIN: RD_LAT cycles with no reads, then go to WRITE.
- WRITE: IFM_DATA_NUM cycles, j = 0..IFM_DATA_NUM-1.
  - w_en=1, w_addr = (g*IFM_DATA_NUM+j)*S + s, w_data = buffer j.
  - On the last j, go to READ for the next (g,s), or to IDLE with ap_done if this was the last (g,s).
- PAD: ifm_w*S cycles, no reads.
  - w_en=1, w_data=0, w_addr runs 0..ifm_w*S-1 in order.
  - Then go to IDLE with ap_done.
- Buffers are cleared on entry to READ, so no stale lanes leak between slices.
- Arithmetic: addresses are computed at full width and truncated to RA_W/WA_W. Configurations within the MAX limits never overflow.

## Timing
- ap_start sampled high at edge T.
- Normal row:
  - First r_en (or first suppressed-read slot) is in cycle T+1.
  - r_data for a read issued in cycle t is captured at the end of cycle t+RD_LAT-1+1, i.e. sampled RD_LAT cycles later.
  - Each (g,s) takes W_BRAM_DATA_W + RD_LAT + IFM_DATA_NUM cycles.
  - The first w_en is in cycle T+1+W_BRAM_DATA_W+RD_LAT.
- Padded row: first w_en in cycle T+1; last in cycle T+ifm_w*S.
- ap_done is high for exactly one cycle, the cycle after the last w_en. ap_busy falls in that same cycle.
- The loader can be restarted in the cycle after ap_done.
- ap_start while busy is ignored; requests are not queued.
- Reset asserted mid-row: next cycle in IDLE, all outputs 0, no ap_done, buffers cleared.
- ap_start held high continuously: a new row starts each time IDLE is reached.

## Test plan
1. IFM_DATA_NUM=4, W=16, RD_LAT=1; ifm_w=8, ifm_h=8, ich=16, line_idx=3; r_data = f(addr) -> 2 groups x 1 slice.
   - 32 reads, starting at r_addr 6, 7 for g=1, 22...
   - 8 writes to w_addr 0..7.
   - Lane k of w_addr x equals pixel x of channel k, row 3.
   - ap_done at T+1+2*(16+1+4).
2. ich=20, ifm_w=4 -> S=2.
   - Slice 1 issues 4 reads and 12 suppressed slots.
   - Writes go to w_addr 1,3,5,7 with lanes 4..15 equal to 0.
3. line_idx=-1, then line_idx=ifm_h=8 (ifm_w=8, ich=32) -> no r_en.
   - 16 zero writes to w_addr 0..15.
   - ap_done at T+17.
4. RD_LAT=3 sweep (also IFM_DATA_NUM=8, W=8) -> data matches the reference model. First w_en at T+1+W+3.
5. Reset pulsed during WRITE of group 0, then ap_start.
   - No ap_done from the aborted row.
   - Outputs 0 in the cycle after reset.
   - Second row fully correct.
   - ap_start pulses during busy are ignored.
